// File: rtl/gfx_pkg.sv
// Shared raster definitions: command modes, engine
// state encoding and default 320x240 geometry.
package gfx_pkg;

  localparam logic MODE_LINE = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LINE,
    FILL,
    FINISH
  } state_t;

  localparam int DEF_X_W     = 9;
  localparam int DEF_Y_W     = 8;
  localparam int DEF_COLOR_W = 9;
  localparam int DEF_X_MAX   = 319;
  localparam int DEF_Y_MAX   = 239;

endpackage

// File: rtl/pix_out_reg.sv
// Registered valid/ready pixel stage; data holds
// while the beat is presented but not accepted.
module pix_out_reg #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [X_W-1:0]     load_x,
  input  logic [Y_W-1:0]     load_y,
  input  logic [COLOR_W-1:0] load_color,
  output logic               free,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color
);

  // Room for a new beat when empty or draining now.
  assign free = !pix_valid || pix_ready;

  // Capture a new beat only when there is room.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
    end else if (load && free) begin
      pix_valid <= 1'b1;
      pix_x     <= load_x;
      pix_y     <= load_y;
      pix_color <= load_color;
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line / filled rectangle rasteriser with
// clipping and a backpressured pixel output stage.
module line_raster_engine
  import gfx_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int X_MAX   = DEF_X_MAX,
  parameter int Y_MAX   = DEF_Y_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_mode,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [X_W-1:0]     cmd_x1,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [Y_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
);

  localparam int CW =
    ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic [X_W-1:0] XLIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YLIM = Y_W'(Y_MAX);

  state_t state, state_n;

  logic               mode_q;
  logic [X_W-1:0]     x0_q, x1_q;
  logic [Y_W-1:0]     y0_q, y1_q;
  logic [COLOR_W-1:0] color_q;

  logic [X_W-1:0]     cur_x, end_x, xmin;
  logic [Y_W-1:0]     cur_y, end_y;
  logic signed [CW-1:0] dx, dy, err, err_n;
  logic               sx_neg, sy_neg;
  logic               tail;

  logic [X_W-1:0]     adx;
  logic [Y_W-1:0]     ady;
  logic signed [CW:0] e2, dxe, dye;
  logic               stx, sty;
  logic               free, run, step;
  logic               at_end, visible, load;

  assign adx = (x1_q >= x0_q) ? x1_q - x0_q
                              : x0_q - x1_q;
  assign ady = (y1_q >= y0_q) ? y1_q - y0_q
                              : y0_q - y1_q;

  assign e2  = {err, 1'b0};
  assign dxe = {dx[CW-1], dx};
  assign dye = {dy[CW-1], dy};
  // Both tests use the error value before this step.
  assign stx = e2 > -dye;
  assign sty = e2 < dxe;

  assign run     = (state == LINE) || (state == FILL);
  assign step    = run && !tail && free;
  assign at_end  = (cur_x == end_x) && (cur_y == end_y);
  assign visible = (cur_x <= XLIM) && (cur_y <= YLIM);
  assign load    = step && visible;

  // Bresenham error update for the next point.
  always_comb begin
    err_n = err;
    if (stx) err_n = err_n - dy;
    if (sty) err_n = err_n + dx;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_n = SETUP;
      end
      SETUP: begin
        state_n = (mode_q == MODE_FILL) ? FILL
                                        : LINE;
      end
      LINE, FILL: begin
        if (tail && free) state_n = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Command latch, setup maths and point stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mode_q  <= cmd_mode;
            x0_q    <= cmd_x0;
            x1_q    <= cmd_x1;
            y0_q    <= cmd_y0;
            y1_q    <= cmd_y1;
            color_q <= cmd_color;
          end
        end
        SETUP: begin
          tail   <= 1'b0;
          dx     <= $signed(CW'(adx));
          dy     <= $signed(CW'(ady));
          err    <= $signed(CW'(adx))
                  - $signed(CW'(ady));
          sx_neg <= x1_q < x0_q;
          sy_neg <= y1_q < y0_q;
          if (mode_q == MODE_FILL) begin
            xmin  <= (x1_q < x0_q) ? x1_q : x0_q;
            cur_x <= (x1_q < x0_q) ? x1_q : x0_q;
            end_x <= (x1_q < x0_q) ? x0_q : x1_q;
            cur_y <= (y1_q < y0_q) ? y1_q : y0_q;
            end_y <= (y1_q < y0_q) ? y0_q : y1_q;
          end else begin
            cur_x <= x0_q;
            cur_y <= y0_q;
            end_x <= x1_q;
            end_y <= y1_q;
          end
        end
        LINE: begin
          if (step) begin
            if (at_end) begin
              tail <= 1'b1;
            end else begin
              err <= err_n;
              if (stx)
                cur_x <= sx_neg ? cur_x - X_W'(1)
                                : cur_x + X_W'(1);
              if (sty)
                cur_y <= sy_neg ? cur_y - Y_W'(1)
                                : cur_y + Y_W'(1);
            end
          end
        end
        FILL: begin
          if (step) begin
            if (at_end) begin
              tail <= 1'b1;
            end else if (cur_x == end_x) begin
              cur_x <= xmin;
              cur_y <= cur_y + Y_W'(1);
            end else begin
              cur_x <= cur_x + X_W'(1);
            end
          end
        end
        default: tail <= 1'b0;
      endcase
    end
  end

  pix_out_reg #(
    .X_W     (X_W),
    .Y_W     (Y_W),
    .COLOR_W (COLOR_W)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_x     (cur_x),
    .load_y     (cur_y),
    .load_color (color_q),
    .free       (free),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color)
  );

endmodule

// File: tb/tb_line_raster_engine.sv
// Scoreboard bench for line_raster_engine: directed
// commands queue expected pixels, a monitor checks.
module tb_line_raster_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_mode = 1'b0;
  logic [8:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [7:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [8:0] cmd_color = '0;
  logic       pix_valid;
  logic       pix_ready = 1'b1;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [8:0] pix_color;
  logic       busy, done;

  line_raster_engine dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_x0    (cmd_x0),
    .cmd_x1    (cmd_x1),
    .cmd_y0    (cmd_y0),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] c;
  } px_t;

  px_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  npix = 0;
  int  ndone = 0;
  int  first_cyc = 0;
  int  last_cyc = 0;
  int  acc_edge = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d",
               nm, act, want);
    end
  endtask

  task automatic exp_px(input int x, input int y,
                        input int c);
    px_t e;
    e.x = 9'(x);
    e.y = 8'(y);
    e.c = 9'(c);
    sb.push_back(e);
  endtask

  task automatic monitor();
    px_t e;
    forever begin
      @(negedge clk);
      if (!rst && pix_valid && pix_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_pixel got=(%0d,%0d,%h)",
                   pix_x, pix_y, pix_color);
        end else begin
          e = sb.pop_front();
          if (pix_x !== e.x || pix_y !== e.y ||
              pix_color !== e.c) begin
            bad++;
            $display("FAIL pixel got=(%0d,%0d,%h) want=(%0d,%0d,%h)",
                     pix_x, pix_y, pix_color,
                     e.x, e.y, e.c);
          end
        end
        if (npix == 0) first_cyc = cyc;
        last_cyc = cyc;
        npix++;
      end
      if (!rst && done) begin
        ndone++;
        chk("done_sb_empty", sb.size(), 0);
        chk("done_no_valid", int'(pix_valid), 0);
      end
    end
  endtask

  task automatic issue(input logic m,
                       input int x0, input int y0,
                       input int x1, input int y1,
                       input int c);
    bit got;
    @(posedge clk); #1;
    cmd_mode  = m;
    cmd_x0    = 9'(x0);
    cmd_y0    = 8'(y0);
    cmd_x1    = 9'(x1);
    cmd_y1    = 8'(y1);
    cmd_color = 9'(c);
    cmd_valid = 1'b1;
    npix = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        acc_edge = cyc + 1;
      end
    end
    chk("cmd_accept", int'(got), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_x0    = 9'h1AA;
    cmd_y0    = 8'h55;
    cmd_x1    = 9'h0F0;
    cmd_y1    = 8'h33;
    cmd_color = 9'h000;
  endtask

  task automatic wait_done(input string nm,
                           input int want_pix);
    int base;
    bit got;
    base = ndone;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    repeat (2) @(negedge clk);
    chk({nm, "_done_once"}, ndone - base, 1);
    chk({nm, "_npix"}, npix, want_pix);
  endtask

  initial begin
    int hx, hy, hc, base;
    bit got;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_pix_color", int'(pix_color), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single point
    exp_px(5, 5, 'h1FF);
    issue(1'b0, 5, 5, 5, 5, 'h1FF);
    @(negedge clk);
    chk("pt_busy", int'(busy), 1);
    chk("pt_cmd_ready", int'(cmd_ready), 0);
    wait_done("point", 1);
    chk("pt_idle_busy", int'(busy), 0);

    // Horizontal: latency and throughput
    for (int i = 0; i < 4; i++) exp_px(i, 0, 'h0A5);
    issue(1'b0, 0, 0, 3, 0, 'h0A5);
    wait_done("horiz", 4);
    chk("horiz_latency", first_cyc - acc_edge, 2);
    chk("horiz_burst", last_cyc - first_cyc, 3);

    // Steep
    exp_px(0, 0, 'h011);
    exp_px(0, 1, 'h011);
    exp_px(1, 2, 'h011);
    exp_px(1, 3, 'h011);
    exp_px(2, 4, 'h011);
    exp_px(2, 5, 'h011);
    issue(1'b0, 0, 0, 2, 5, 'h011);
    wait_done("steep", 6);

    // Reverse diagonal
    for (int i = 0; i < 4; i++)
      exp_px(10 - i, 10 - i, 'h122);
    issue(1'b0, 10, 10, 7, 7, 'h122);
    wait_done("reverse", 4);

    // Right-edge clip
    exp_px(318, 0, 'h0C3);
    exp_px(319, 0, 'h0C3);
    issue(1'b0, 318, 0, 321, 0, 'h0C3);
    wait_done("clip", 2);

    // Rectangle with swapped corners
    exp_px(2, 3, 'h1E0);
    exp_px(3, 3, 'h1E0);
    exp_px(2, 4, 'h1E0);
    exp_px(3, 4, 'h1E0);
    issue(1'b1, 3, 4, 2, 3, 'h1E0);
    wait_done("fill", 4);

    // Fully clipped rectangle
    issue(1'b1, 400, 0, 401, 1, 'h0FF);
    wait_done("fill_clip", 0);

    // Backpressure mid-line
    for (int i = 0; i < 10; i++) exp_px(i, 0, 'h0AA);
    issue(1'b0, 0, 0, 9, 0, 'h0AA);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (npix >= 2) got = 1;
    end
    chk("bp_reach", int'(got), 1);
    pix_ready = 1'b0;
    @(negedge clk);
    hx = int'(pix_x);
    hy = int'(pix_y);
    hc = int'(pix_color);
    chk("bp_valid", int'(pix_valid), 1);
    chk("bp_held_x", hx, 2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_x", int'(pix_x), hx);
      chk("bp_y", int'(pix_y), hy);
      chk("bp_c", int'(pix_color), hc);
      chk("bp_cmd_ready", int'(cmd_ready), 0);
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    wait_done("bp", 10);

    // Reset mid-command
    for (int i = 0; i < 10; i++) exp_px(i, 0, 'h055);
    issue(1'b0, 0, 0, 9, 0, 'h055);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (npix >= 1) got = 1;
    end
    chk("rstm_reach", int'(got), 1);
    base = ndone;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstm_pix_valid", int'(pix_valid), 0);
    chk("rstm_cmd_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstm_no_done", ndone - base, 0);
    chk("rstm_npix", npix, 1);
    chk("rstm_busy", int'(busy), 0);
    sb.delete();

    // Normal command after abort
    exp_px(7, 9, 'h123);
    issue(1'b0, 7, 9, 7, 9, 'h123);
    wait_done("post_rst", 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
